apbm_swc_dec: RTL and testbench
===============================

Name: apbm_swc_dec

Overview:
Parametrised APB master bridge, successor of the single-slave bridge. It takes write requests from a write-buffer FIFO and read requests from a read-address FIFO and arbitrates between them round-robin. Each address is decoded onto one of PD_NUM slave selects, and the slave's pready/prdata/pslverr are muxed back. It adds byte strobes, decode-error and timeout responses, and reports a 2-bit completion code to the buffer side.

Parameters:
ADDR_W, 32, paddr / buffer address width
DATA_W, 32, data width (multiple of 8)
PD_NUM, 3, number of peripheral slaves (1..16)
PD_AW, 8, per-slave window address bits; slave index = addr[PD_AW +: IDX_W], IDX_W = max(1, clog2(PD_NUM))
TIMEOUT, 16, max ACCESS cycles without pready before abort; 0 disables the timeout

Ports:
pclk  in  1  clock
prst  in  1  synchronous reset, active-high
paddr  out  ADDR_W  APB address
psel  out  PD_NUM  one-hot slave select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
pstrb  out  DATA_W/8  write strobes; all 0 on reads
pready  in  PD_NUM  per-slave ready
prdata  in  PD_NUM*DATA_W  per-slave read data, slave i at [i*DATA_W +: DATA_W]
pslverr  in  PD_NUM  per-slave error
wreq  in  1  write FIFO non-empty
wbuffdata  in  DATA_W  write FIFO head data
wbuffaddr  in  ADDR_W  write FIFO head address
wbuffstrb  in  DATA_W/8  write FIFO head strobes
wbuffread  out  1  write FIFO pop pulse
rreq  in  1  read-address FIFO non-empty
rbuffaddr  in  ADDR_W  read FIFO head address
rbuffread  out  1  read-address FIFO pop pulse
rbuffwrite  out  1  read-data push pulse
rbuffdata  out  DATA_W  read data to push
done  out  1  one-cycle completion pulse
resp  out  2  completion code: 00 OKAY, 01 SLVERR, 10 DECERR, 11 TIMEOUT

Behaviour:
- All outputs registered. Reset values: all 0. prst in any state forces IDLE on the next edge, clears the timeout counter, and issues no done; the aborted transfer is lost and the FIFO pop already issued is not undone.
- States: IDLE, SETUP, ACCESS, ERR.
- IDLE: if wreq or rreq, grant per arbiter and latch addr/data/strb/dir.
  - Decoded index >= PD_NUM, or addr bits above PD_AW+IDX_W non-zero -> ERR.
  - Otherwise -> SETUP.
  - Pop pulse (wbuffread or rbuffread) asserts in the cycle the state becomes SETUP or ERR.
- Arbiter: only one request -> grant it. Both -> grant the opposite of the last grant. Last-grant reset value = read, so write wins the first tie.
- SETUP (1 cycle): psel[idx]=1, penable=0; paddr/pwrite/pwdata/pstrb valid and held stable until ACCESS exits. -> ACCESS.
- ACCESS: penable=1, sample the muxed pready[idx].
  - pready=1: complete. Next cycle done=1 and resp = pslverr[idx] ? 01 : 00.
  - On a read, rbuffwrite=1 and rbuffdata = prdata slice, pushed even on SLVERR.
  - Next state: SETUP if wreq|rreq (back-to-back, arbiter re-evaluated, psel stays high if the same slave is selected), else IDLE with psel/penable/paddr/pwdata cleared.
- Timeout: counter increments each ACCESS cycle without pready, cleared on entry.
  - When TIMEOUT != 0 and the count reaches TIMEOUT with pready still low: drop psel/penable, go to IDLE, next cycle done=1 with resp=11.
  - On a read, push rbuffdata=0 with rbuffwrite=1.
  - pready arriving in the same cycle as the limit wins (normal completion).
- ERR (1 cycle): no psel/penable. Next cycle done=1, resp=10; on a read, push rbuffdata=0 with rbuffwrite=1. -> IDLE.
- Minimum latency: request in IDLE to done = 4 cycles with a zero-wait slave. Back-to-back throughput: one transfer per 2 cycles.
- done, rbuffwrite and the pop pulses are single-cycle and never high two consecutive cycles for the same transfer. rbuffdata is 0 when rbuffwrite=0.

Decomposition:
- Package apb_swc_pkg: state enum (IDLE/SETUP/ACCESS/ERR), resp codes (RESP_OKAY/SLVERR/DECERR/TIMEOUT), clog2 function.
- Sub-module apbm_addr_dec: combinational address -> {valid, idx, one-hot sel}, parametrised by ADDR_W/PD_NUM/PD_AW.

Test Plan:
- Write 0x0000_0104, data 0xDEAD_BEEF, strb 0xF, slave 1 pready immediate -> psel=3'b010, pstrb=4'hF; done at cycle 4 with resp=00; exactly one wbuffread.
- wreq and rreq both high from reset, addrs 0x0000_0008 / 0x0000_0208 -> write first, then read on psel=3'b100 back-to-back with no IDLE cycle between; rbuffdata = slave-2 prdata 0x1234_5678.
- Read 0x0000_0300 (index 3, PD_NUM=3) -> no psel asserted; done with resp=10; rbuffwrite=1 with rbuffdata=0.
- Slave 0 holds pready low, TIMEOUT=16 -> abort after 16 ACCESS cycles, resp=11. Repeat with pready rising in cycle 16 -> resp=00.
- Read with pslverr=1 on pready -> resp=01, rbuffwrite=1 carrying prdata.
- prst asserted in ACCESS -> next edge: all outputs 0, state IDLE, no done pulse. A new request then completes normally.

Source files
------------

// File: rtl/apb_swc_pkg.sv
// Shared types for the multi-slave APB master bridge: FSM states, completion codes
// and a constant-evaluable clog2.
package apb_swc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      ERR
   } state_e;

   typedef enum logic [1:0] {
      RESP_OKAY    = 2'b00,
      RESP_SLVERR  = 2'b01,
      RESP_DECERR  = 2'b10,
      RESP_TIMEOUT = 2'b11
   } resp_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/apbm_swc_dec_if.sv
// Bus bundle of the bridge: APB side towards the slaves plus the write/read FIFO side.
interface apbm_swc_dec_if
   import apb_swc_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int PD_NUM = 3
);
   logic [ADDR_W-1:0]        paddr;
   logic [PD_NUM-1:0]        psel;
   logic                     penable;
   logic                     pwrite;
   logic [DATA_W-1:0]        pwdata;
   logic [DATA_W/8-1:0]      pstrb;
   logic [PD_NUM-1:0]        pready;
   logic [PD_NUM*DATA_W-1:0] prdata;
   logic [PD_NUM-1:0]        pslverr;
   logic                     wreq;
   logic [DATA_W-1:0]        wbuffdata;
   logic [ADDR_W-1:0]        wbuffaddr;
   logic [DATA_W/8-1:0]      wbuffstrb;
   logic                     wbuffread;
   logic                     rreq;
   logic [ADDR_W-1:0]        rbuffaddr;
   logic                     rbuffread;
   logic                     rbuffwrite;
   logic [DATA_W-1:0]        rbuffdata;
   logic                     done;
   resp_e                    resp;

   modport master (
      output paddr, psel, penable, pwrite, pwdata, pstrb,
      output wbuffread, rbuffread, rbuffwrite, rbuffdata, done, resp,
      input  pready, prdata, pslverr,
      input  wreq, wbuffdata, wbuffaddr, wbuffstrb, rreq, rbuffaddr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, pstrb,
      input  wbuffread, rbuffread, rbuffwrite, rbuffdata, done, resp,
      output pready, prdata, pslverr,
      output wreq, wbuffdata, wbuffaddr, wbuffstrb, rreq, rbuffaddr
   );

endinterface

// File: rtl/apbm_addr_dec.sv
// Address decoder: maps an address onto one of PD_NUM slave windows; any address
// outside the populated windows (index too large or high bits set) is invalid.
module apbm_addr_dec
   import apb_swc_pkg::*;
#(
   parameter  int ADDR_W = 32,
   parameter  int PD_NUM = 3,
   parameter  int PD_AW  = 8,
   localparam int IDX_W  = (PD_NUM > 1) ? clog2(PD_NUM) : 1
)(
   input  logic [ADDR_W-1:0] addr_i,
   output logic              valid_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic [PD_NUM-1:0] sel_o
);

   logic [ADDR_W-1:0] win;

   always_comb begin
      win     = addr_i >> PD_AW;
      idx_o   = win[IDX_W-1:0];
      valid_o = (32'(idx_o) < PD_NUM) && ((win >> IDX_W) == '0);
      sel_o   = '0;
      for (int i = 0; i < PD_NUM; i++) begin
         sel_o[i] = valid_o && (idx_o == IDX_W'(i));
      end
   end

endmodule

// File: rtl/apbm_swc_dec.sv
// Round-robin APB master bridge: serves write-FIFO and read-FIFO requests onto
// PD_NUM decoded slaves, with decode-error and timeout completion codes.
module apbm_swc_dec
   import apb_swc_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int PD_NUM  = 3,
   parameter int PD_AW   = 8,
   parameter int TIMEOUT = 16
)(
   input  logic           pclk,
   input  logic           prst,
   apbm_swc_dec_if.master bus
);

   localparam int IDX_W  = (PD_NUM > 1) ? clog2(PD_NUM) : 1;
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_e              state_q, state_d;
   logic                last_wr_q, last_wr_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic [STRB_W-1:0]   pstrb_q, pstrb_d;
   logic                pwrite_q, pwrite_d;
   logic [PD_NUM-1:0]   psel_q, psel_d;
   logic                penable_q, penable_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                done_q, done_d;
   resp_e               resp_q, resp_d;
   logic                rbuffwrite_q, rbuffwrite_d;
   logic [DATA_W-1:0]   rbuffdata_q, rbuffdata_d;
   logic                wbuffread_q, wbuffread_d;
   logic                rbuffread_q, rbuffread_d;

   logic                req_any, grant_wr, dec_valid, launch, retire;
   logic [ADDR_W-1:0]   cand_addr;
   logic [IDX_W-1:0]    dec_idx;
   logic [PD_NUM-1:0]   dec_sel;
   logic                sl_ready, sl_err;
   logic [DATA_W-1:0]   sl_rdata;

   // On a tie the side that did not win last time gets the grant.
   assign req_any   = bus.wreq | bus.rreq;
   assign grant_wr  = bus.wreq & (~bus.rreq | ~last_wr_q);
   assign cand_addr = grant_wr ? bus.wbuffaddr : bus.rbuffaddr;

   apbm_addr_dec #(
      .ADDR_W (ADDR_W),
      .PD_NUM (PD_NUM),
      .PD_AW  (PD_AW)
   ) u_addr_dec (
      .addr_i  (cand_addr),
      .valid_o (dec_valid),
      .idx_o   (dec_idx),
      .sel_o   (dec_sel)
   );

   always_comb begin
      sl_ready = 1'b0;
      sl_err   = 1'b0;
      sl_rdata = '0;
      for (int i = 0; i < PD_NUM; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sl_ready = bus.pready[i];
            sl_err   = bus.pslverr[i];
            sl_rdata = bus.prdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      last_wr_d    = last_wr_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      pstrb_d      = pstrb_q;
      pwrite_d     = pwrite_q;
      psel_d       = psel_q;
      penable_d    = penable_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      done_d       = 1'b0;
      resp_d       = RESP_OKAY;
      rbuffwrite_d = 1'b0;
      rbuffdata_d  = '0;
      wbuffread_d  = 1'b0;
      rbuffread_d  = 1'b0;
      launch       = 1'b0;
      retire       = 1'b0;

      unique case (state_q)
         IDLE: launch = req_any;
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
            cnt_d     = '0;
         end
         ACCESS: begin
            if (sl_ready) begin
               done_d       = 1'b1;
               resp_d       = sl_err ? RESP_SLVERR : RESP_OKAY;
               rbuffwrite_d = ~pwrite_q;
               rbuffdata_d  = pwrite_q ? '0 : sl_rdata;
               retire       = 1'b1;
               launch       = req_any;
            end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
               done_d       = 1'b1;
               resp_d       = RESP_TIMEOUT;
               rbuffwrite_d = ~pwrite_q;
               retire       = 1'b1;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ERR: begin
            done_d       = 1'b1;
            resp_d       = RESP_DECERR;
            rbuffwrite_d = ~pwrite_q;
            retire       = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (retire) begin
         state_d   = IDLE;
         psel_d    = '0;
         penable_d = 1'b0;
         paddr_d   = '0;
         pwdata_d  = '0;
         pstrb_d   = '0;
         pwrite_d  = 1'b0;
      end

      // A new grant overrides the retire clear, giving back-to-back transfers.
      if (launch) begin
         last_wr_d   = grant_wr;
         pwrite_d    = grant_wr;
         paddr_d     = cand_addr;
         pwdata_d    = grant_wr ? bus.wbuffdata : '0;
         pstrb_d     = grant_wr ? bus.wbuffstrb : '0;
         idx_d       = dec_idx;
         penable_d   = 1'b0;
         wbuffread_d = grant_wr;
         rbuffread_d = ~grant_wr;
         state_d     = dec_valid ? SETUP : ERR;
         psel_d      = dec_sel;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge pclk) begin
      if (prst) begin
         state_q      <= IDLE;
         last_wr_q    <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         pstrb_q      <= '0;
         pwrite_q     <= 1'b0;
         psel_q       <= '0;
         penable_q    <= 1'b0;
         idx_q        <= '0;
         cnt_q        <= '0;
         done_q       <= 1'b0;
         resp_q       <= RESP_OKAY;
         rbuffwrite_q <= 1'b0;
         rbuffdata_q  <= '0;
         wbuffread_q  <= 1'b0;
         rbuffread_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_wr_q    <= last_wr_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         pstrb_q      <= pstrb_d;
         pwrite_q     <= pwrite_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         done_q       <= done_d;
         resp_q       <= resp_d;
         rbuffwrite_q <= rbuffwrite_d;
         rbuffdata_q  <= rbuffdata_d;
         wbuffread_q  <= wbuffread_d;
         rbuffread_q  <= rbuffread_d;
      end
   end

   assign bus.paddr      = paddr_q;
   assign bus.pwdata     = pwdata_q;
   assign bus.pstrb      = pstrb_q;
   assign bus.pwrite     = pwrite_q;
   assign bus.psel       = psel_q;
   assign bus.penable    = penable_q;
   assign bus.done       = done_q;
   assign bus.resp       = resp_q;
   assign bus.rbuffwrite = rbuffwrite_q;
   assign bus.rbuffdata  = rbuffdata_q;
   assign bus.wbuffread  = wbuffread_q;
   assign bus.rbuffread  = rbuffread_q;

endmodule

// File: tb/tb_apbm_swc_dec.sv
// Directed bench for apbm_swc_dec: hand-computed expectations for decode, arbitration,
// error/timeout responses and reset abort.
module tb_apbm_swc_dec;

   logic pclk;
   logic prst;
   int   checks;
   int   errors;

   apbm_swc_dec_if #(.ADDR_W(32), .DATA_W(32), .PD_NUM(3)) bus ();

   apbm_swc_dec #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .PD_NUM  (3),
      .PD_AW   (8),
      .TIMEOUT (16)
   ) dut (
      .pclk (pclk),
      .prst (prst),
      .bus  (bus)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Outputs settle right after the edge; both sampling and driving happen 1 ns later.
   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      prst          = 1'b1;
      bus.wreq      = 1'b0;
      bus.rreq      = 1'b0;
      bus.wbuffaddr = '0;
      bus.wbuffdata = '0;
      bus.wbuffstrb = '0;
      bus.rbuffaddr = '0;
      bus.pready    = 3'b111;
      bus.pslverr   = 3'b000;
      bus.prdata    = {32'h1234_5678, 32'hA5A5_0001, 32'hCAFE_F00D};
      repeat (2) tick();

      check("rst_psel",    bus.psel,       3'b000);
      check("rst_penable", bus.penable,    1'b0);
      check("rst_paddr",   bus.paddr,      32'h0);
      check("rst_done",    bus.done,       1'b0);
      check("rst_resp",    bus.resp,       2'b00);
      check("rst_pops",    {bus.wbuffread, bus.rbuffread, bus.rbuffwrite}, 3'b000);

      // Single write to slave 1; cycle 1 = IDLE with request, done in cycle 4.
      prst          = 1'b0;
      bus.wreq      = 1'b1;
      bus.wbuffaddr = 32'h0000_0104;
      bus.wbuffdata = 32'hDEAD_BEEF;
      bus.wbuffstrb = 4'hF;
      tick();
      check("w_setup_psel",  bus.psel,      3'b010);
      check("w_setup_pen",   bus.penable,   1'b0);
      check("w_setup_paddr", bus.paddr,     32'h0000_0104);
      check("w_setup_pwr",   bus.pwrite,    1'b1);
      check("w_setup_wdata", bus.pwdata,    32'hDEAD_BEEF);
      check("w_setup_strb",  bus.pstrb,     4'hF);
      check("w_setup_pop",   bus.wbuffread, 1'b1);
      check("w_setup_done",  bus.done,      1'b0);
      bus.wreq = 1'b0;
      tick();
      check("w_acc_pen",  bus.penable,   1'b1);
      check("w_acc_psel", bus.psel,      3'b010);
      check("w_acc_pop",  bus.wbuffread, 1'b0);
      check("w_acc_done", bus.done,      1'b0);
      tick();
      check("w_done",      bus.done,       1'b1);
      check("w_resp",      bus.resp,       2'b00);
      check("w_done_psel", bus.psel,       3'b000);
      check("w_done_pen",  bus.penable,    1'b0);
      check("w_done_rbw",  bus.rbuffwrite, 1'b0);
      check("w_done_pop",  bus.wbuffread,  1'b0);
      tick();
      check("w_done_pulse", bus.done, 1'b0);

      // Both requests high out of reset: write wins the first tie, read follows back-to-back.
      prst = 1'b1;
      tick();
      bus.wreq      = 1'b1;
      bus.rreq      = 1'b1;
      bus.wbuffaddr = 32'h0000_0008;
      bus.wbuffdata = 32'h0BAD_F00D;
      bus.wbuffstrb = 4'h3;
      bus.rbuffaddr = 32'h0000_0208;
      tick();
      prst = 1'b0;
      tick();
      check("rr_w_psel", bus.psel,   3'b001);
      check("rr_w_pwr",  bus.pwrite, 1'b1);
      check("rr_w_strb", bus.pstrb,  4'h3);
      check("rr_w_pops", {bus.wbuffread, bus.rbuffread}, 2'b10);
      tick();
      check("rr_w_pen", bus.penable, 1'b1);
      tick();
      check("rr_w_done",  bus.done,     1'b1);
      check("rr_w_resp",  bus.resp,     2'b00);
      check("rr_r_psel",  bus.psel,     3'b100);
      check("rr_r_pen",   bus.penable,  1'b0);
      check("rr_r_pwr",   bus.pwrite,   1'b0);
      check("rr_r_paddr", bus.paddr,    32'h0000_0208);
      check("rr_r_strb",  bus.pstrb,    4'h0);
      check("rr_r_pops",  {bus.wbuffread, bus.rbuffread}, 2'b01);
      bus.wreq = 1'b0;
      bus.rreq = 1'b0;
      tick();
      check("rr_r_acc",  {bus.penable, bus.psel}, 4'b1100);
      check("rr_r_nod",  bus.done, 1'b0);
      tick();
      check("rr_r_done", bus.done,       1'b1);
      check("rr_r_rbw",  bus.rbuffwrite, 1'b1);
      check("rr_r_data", bus.rbuffdata,  32'h1234_5678);
      check("rr_r_idle", bus.psel,       3'b000);
      tick();
      check("rr_r_rbw_pulse", bus.rbuffwrite, 1'b0);
      check("rr_r_data_zero", bus.rbuffdata,  32'h0);

      // Decode errors: index 3 on a read, then a high address bit on a write.
      bus.rreq      = 1'b1;
      bus.rbuffaddr = 32'h0000_0300;
      tick();
      check("de_r_psel", {bus.psel, bus.penable}, 4'b0000);
      check("de_r_pop",  bus.rbuffread, 1'b1);
      bus.rreq = 1'b0;
      tick();
      check("de_r_done", bus.done,       1'b1);
      check("de_r_resp", bus.resp,       2'b10);
      check("de_r_rbw",  bus.rbuffwrite, 1'b1);
      check("de_r_data", bus.rbuffdata,  32'h0);
      check("de_r_psel2", bus.psel,      3'b000);
      bus.wreq      = 1'b1;
      bus.wbuffaddr = 32'h0000_0400;
      tick();
      check("de_w_psel", bus.psel,      3'b000);
      check("de_w_pop",  bus.wbuffread, 1'b1);
      bus.wreq = 1'b0;
      tick();
      check("de_w_done", bus.done,       1'b1);
      check("de_w_resp", bus.resp,       2'b10);
      check("de_w_rbw",  bus.rbuffwrite, 1'b0);

      // Slave 0 never ready: aborted after its 16th ACCESS cycle.
      bus.pready    = 3'b110;
      bus.rreq      = 1'b1;
      bus.rbuffaddr = 32'h0000_0010;
      tick();
      check("to_psel", bus.psel, 3'b001);
      bus.rreq = 1'b0;
      tick();
      repeat (15) tick();
      check("to_c16_acc",  {bus.penable, bus.psel}, 4'b1001);
      check("to_c16_done", bus.done, 1'b0);
      tick();
      check("to_done", bus.done,       1'b1);
      check("to_resp", bus.resp,       2'b11);
      check("to_bus",  {bus.penable, bus.psel}, 4'b0000);
      check("to_rbw",  bus.rbuffwrite, 1'b1);
      check("to_data", bus.rbuffdata,  32'h0);
      tick();
      check("to_done_pulse", bus.done, 1'b0);

      // Same again, but pready arrives in the 16th ACCESS cycle: normal completion wins.
      bus.rreq = 1'b1;
      tick();
      bus.rreq = 1'b0;
      tick();
      repeat (15) tick();
      bus.pready = 3'b111;
      tick();
      check("tl_done", bus.done,       1'b1);
      check("tl_resp", bus.resp,       2'b00);
      check("tl_rbw",  bus.rbuffwrite, 1'b1);
      check("tl_data", bus.rbuffdata,  32'hCAFE_F00D);

      // Slave error on a read still pushes the read data.
      bus.pslverr   = 3'b010;
      bus.rreq      = 1'b1;
      bus.rbuffaddr = 32'h0000_0100;
      tick();
      bus.rreq = 1'b0;
      tick();
      tick();
      check("se_done", bus.done,       1'b1);
      check("se_resp", bus.resp,       2'b01);
      check("se_rbw",  bus.rbuffwrite, 1'b1);
      check("se_data", bus.rbuffdata,  32'hA5A5_0001);
      bus.pslverr = 3'b000;

      // Reset in ACCESS: bus clears, no done, then a fresh read completes.
      bus.pready    = 3'b110;
      bus.wreq      = 1'b1;
      bus.wbuffaddr = 32'h0000_0004;
      bus.wbuffdata = 32'h1122_3344;
      bus.wbuffstrb = 4'hC;
      tick();
      bus.wreq = 1'b0;
      tick();
      check("ra_acc", bus.penable, 1'b1);
      prst = 1'b1;
      tick();
      check("ra_psel",  bus.psel,    3'b000);
      check("ra_pen",   bus.penable, 1'b0);
      check("ra_paddr", bus.paddr,   32'h0);
      check("ra_wdata", bus.pwdata,  32'h0);
      check("ra_strb",  bus.pstrb,   4'h0);
      check("ra_pwr",   bus.pwrite,  1'b0);
      check("ra_done",  bus.done,    1'b0);
      prst       = 1'b0;
      bus.pready = 3'b111;
      tick();
      check("ra_nodone", bus.done, 1'b0);
      check("ra_idle",   bus.psel, 3'b000);
      bus.rreq      = 1'b1;
      bus.rbuffaddr = 32'h0000_0108;
      tick();
      check("ra_new_psel", bus.psel, 3'b010);
      bus.rreq = 1'b0;
      tick();
      tick();
      check("ra_new_done", bus.done,      1'b1);
      check("ra_new_resp", bus.resp,      2'b00);
      check("ra_new_data", bus.rbuffdata, 32'hA5A5_0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
